// File: rtl/dice_pkg.sv
// Shared types and constants for the electronic die roll engine.
package dice_pkg;

  localparam int DICE_WIDTH              = 7;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROLLING = 2'd1,
    HOLD    = 2'd2
  } state_t;

endpackage

// File: rtl/roll_debouncer.sv
// Button filter: two-flop synchronizer followed by a stable-count debouncer.
// Only instantiated when DICE_DEBOUNCE_EN is defined.
module roll_debouncer #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(CYCLES + 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] stable_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Any sample that agrees with the current level restarts the run of differing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level        <= 1'b0;
      stable_count <= '0;
    end else if (sync_b == level) begin
      stable_count <= '0;
    end else if (stable_count == CW'(CYCLES - 1)) begin
      level        <= sync_b;
      stable_count <= '0;
    end else begin
      stable_count <= stable_count + CW'(1);
    end
  end

endmodule

// File: rtl/dice_roll_counter.sv
// Roll engine: cycles a counter through Min..Max while Roll is held, then offers
// the frozen result with a valid/ack handshake. Optional filter: DICE_DEBOUNCE_EN.
module dice_roll_counter
  import dice_pkg::*;
#(
  parameter int WIDTH           = DICE_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] Min,
  input  logic [WIDTH-1:0] Max,
  input  logic             Roll,
  input  logic             Ack,
  output logic [WIDTH-1:0] Value,
  output logic             Valid,
  output logic             Busy
);

  logic roll_level;

`ifdef DICE_DEBOUNCE_EN
  roll_debouncer #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_roll_debouncer (
    .clk  (Clk),
    .rst  (Reset),
    .raw  (Roll),
    .level(roll_level)
  );
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES > 0);
  assign roll_level      = Roll;
`endif

  state_t           state;
  state_t           state_next;
  logic             capture;
  logic             latch_result;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next   = state;
    capture      = 1'b0;
    latch_result = 1'b0;
    case (state)
      IDLE: begin
        if (roll_level) begin
          state_next = ROLLING;
          capture    = 1'b1;
        end
      end
      ROLLING: begin
        if (!roll_level) begin
          state_next   = HOLD;
          latch_result = 1'b1;
        end
      end
      HOLD: begin
        if (Ack) begin
          state_next = roll_level ? ROLLING : IDLE;
          capture    = roll_level;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Wrap compare precedes the increment, so an inverted range simply reloads Min.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
      min_q <= '0;
      max_q <= '0;
      Value <= '0;
    end else begin
      if (capture) begin
        min_q <= Min;
        max_q <= Max;
        count <= Min;
      end else if (state == ROLLING && roll_level) begin
        count <= (count >= max_q) ? min_q : count + WIDTH'(1);
      end
      if (latch_result) Value <= count;
    end
  end

  assign Busy  = (state == ROLLING);
  assign Valid = (state == HOLD);

endmodule
